// File: rtl/sys_bus_arbiter_pkg.sv
// Shared types and helpers for the system-bus arbiter: FSM encoding,
// completion error mapping and a constant-width helper.
package sys_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // A forced timeout completion always reports an error; otherwise the slave decides.
  function automatic logic resp_err(input logic timed_out, input logic sys_err);
    return timed_out | sys_err;
  endfunction

endpackage

// File: rtl/sys_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first pending index after last_i,
// wrapping modulo N_MST.
module sys_bus_arbiter_rr_pick
  import sys_bus_arbiter_pkg::*;
#(
  parameter int N_MST = 2,
  parameter int IW    = clog2(N_MST)
) (
  input  logic [N_MST-1:0] pend_i,
  input  logic [IW-1:0]    last_i,
  output logic [IW-1:0]    grant_o,
  output logic             any_o
);

  always_comb begin
    int idx;
    idx     = 0;
    grant_o = '0;
    any_o   = 1'b0;
    for (int i = 1; i <= N_MST; i++) begin
      idx = (int'(last_i) + i) % N_MST;
      if (!any_o && pend_i[IW'(idx)]) begin
        any_o   = 1'b1;
        grant_o = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter sharing one downstream system bus between N_MST masters,
// with one pending slot per master and a per-transaction ack timeout.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no transaction on the bus; grant the next pending slot
// ST_ISSUE | wen/ren pulse on the bus; ack already accepted this cycle
// ST_WAIT  | waiting for ack; tmo_q counts cycles toward forced error
module sys_bus_arbiter
  import sys_bus_arbiter_pkg::*;
#(
  parameter int N_MST   = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TMO_CYC = 32
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [N_MST*AW-1:0] m_addr_i,
  input  logic [N_MST*DW-1:0] m_wdata_i,
  input  logic [N_MST-1:0]    m_wen_i,
  input  logic [N_MST-1:0]    m_ren_i,
  output logic [N_MST*DW-1:0] m_rdata_o,
  output logic [N_MST-1:0]    m_err_o,
  output logic [N_MST-1:0]    m_ack_o,
  output logic [AW-1:0]       sys_addr_o,
  output logic [DW-1:0]       sys_wdata_o,
  output logic                sys_wen_o,
  output logic                sys_ren_o,
  input  logic [DW-1:0]       sys_rdata_i,
  input  logic                sys_err_i,
  input  logic                sys_ack_i,
  output logic [N_MST-1:0]    ovr_o
);

  localparam int IW = clog2(N_MST);
  localparam int TW = clog2(TMO_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  logic [N_MST-1:0] req, clr;
  logic [N_MST-1:0] pend_q, wr_q, ovr_q;
  logic [AW-1:0]    addr_q  [N_MST];
  logic [DW-1:0]    wdata_q [N_MST];

  state_e           state_q;
  logic [IW-1:0]    grant_q, rr_last_q, pick_idx;
  logic             pick_any;
  logic [TW-1:0]    tmo_q;
  logic [AW-1:0]    sys_addr_q;
  logic [DW-1:0]    sys_wdata_q;
  logic             sys_wen_q, sys_ren_q;
  logic [N_MST-1:0] m_ack_q, m_err_q;
  logic [N_MST*DW-1:0] m_rdata_q;

  logic             busy, ack_seen, tmo_hit, done, done_err;
  logic [DW-1:0]    done_rdata;

  assign req        = m_wen_i | m_ren_i;
  assign busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign ack_seen   = busy && sys_ack_i;
  assign tmo_hit    = (state_q == ST_WAIT) && !sys_ack_i && (tmo_q == TMO_LAST);
  assign done       = ack_seen || tmo_hit;
  assign done_err   = resp_err(tmo_hit, sys_err_i);
  assign done_rdata = (ack_seen && !wr_q[grant_q]) ? sys_rdata_i : '0;

  always_comb begin
    clr = '0;
    if (done) clr[grant_q] = 1'b1;
  end

  sys_bus_arbiter_rr_pick #(
    .N_MST (N_MST),
    .IW    (IW)
  ) u_rr_pick (
    .pend_i  (pend_q),
    .last_i  (rr_last_q),
    .grant_o (pick_idx),
    .any_o   (pick_any)
  );

  // Clear and capture never hit the same slot: capture needs pend_q=0, clear needs pend_q=1.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pend_q <= '0;
      wr_q   <= '0;
      ovr_q  <= '0;
      for (int k = 0; k < N_MST; k++) begin
        addr_q[k]  <= '0;
        wdata_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_MST; k++) begin
        if (clr[k]) pend_q[k] <= 1'b0;
        if (req[k]) begin
          if (pend_q[k]) begin
            ovr_q[k] <= 1'b1;
          end else begin
            pend_q[k]  <= 1'b1;
            wr_q[k]    <= m_wen_i[k];
            addr_q[k]  <= m_addr_i[k*AW +: AW];
            wdata_q[k] <= m_wdata_i[k*DW +: DW];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_last_q   <= IW'(N_MST - 1);
      tmo_q       <= '0;
      sys_addr_q  <= '0;
      sys_wdata_q <= '0;
      sys_wen_q   <= 1'b0;
      sys_ren_q   <= 1'b0;
      m_ack_q     <= '0;
      m_err_q     <= '0;
      m_rdata_q   <= '0;
    end else begin
      sys_wen_q <= 1'b0;
      sys_ren_q <= 1'b0;
      m_ack_q   <= '0;
      if (done) begin
        m_ack_q[grant_q]                  <= 1'b1;
        m_err_q[grant_q]                  <= done_err;
        m_rdata_q[int'(grant_q)*DW +: DW] <= done_rdata;
      end
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q     <= pick_idx;
            rr_last_q   <= pick_idx;
            sys_addr_q  <= addr_q[pick_idx];
            sys_wdata_q <= wdata_q[pick_idx];
            sys_wen_q   <= wr_q[pick_idx];
            sys_ren_q   <= !wr_q[pick_idx];
            tmo_q       <= '0;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (done) begin
            state_q <= ST_IDLE;
          end else begin
            tmo_q   <= tmo_q + 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (done) state_q <= ST_IDLE;
          else      tmo_q   <= tmo_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sys_addr_o  = sys_addr_q;
  assign sys_wdata_o = sys_wdata_q;
  assign sys_wen_o   = sys_wen_q;
  assign sys_ren_o   = sys_ren_q;
  assign m_ack_o     = m_ack_q;
  assign m_err_o     = m_err_q;
  assign m_rdata_o   = m_rdata_q;
  assign ovr_o       = ovr_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Self-checking bench for sys_bus_arbiter: table of single transactions plus
// hand sequences for rotation, overrun, timeout and mid-transaction reset.
module tb_sys_bus_arbiter;
  localparam int N   = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 32;

  logic            clk_i = 1'b0;
  logic            rstn_i = 1'b0;
  logic [N*AW-1:0] m_addr_i = '0;
  logic [N*DW-1:0] m_wdata_i = '0;
  logic [N-1:0]    m_wen_i = '0;
  logic [N-1:0]    m_ren_i = '0;
  logic [N*DW-1:0] m_rdata_o;
  logic [N-1:0]    m_err_o, m_ack_o, ovr_o;
  logic [AW-1:0]   sys_addr_o;
  logic [DW-1:0]   sys_wdata_o;
  logic            sys_wen_o, sys_ren_o;
  logic [DW-1:0]   sys_rdata_i = '0;
  logic            sys_err_i = 1'b0;
  logic            sys_ack_i = 1'b0;

  sys_bus_arbiter #(.N_MST(N), .AW(AW), .DW(DW), .TMO_CYC(TMO)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_wen_i(m_wen_i), .m_ren_i(m_ren_i),
    .m_rdata_o(m_rdata_o), .m_err_o(m_err_o), .m_ack_o(m_ack_o),
    .sys_addr_o(sys_addr_o), .sys_wdata_o(sys_wdata_o), .sys_wen_o(sys_wen_o), .sys_ren_o(sys_ren_o),
    .sys_rdata_i(sys_rdata_i), .sys_err_i(sys_err_i), .sys_ack_i(sys_ack_i), .ovr_o(ovr_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] wdata; bit w; } iss_t;
  typedef struct { int m; bit err; logic [DW-1:0] rdata; } cpl_t;
  iss_t iss_q[$];
  cpl_t cpl_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int iss_cyc = 0, ack_cyc = 0, ack_count = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model: mode 0 acks slv_dly cycles after the pulse, mode 1 never acks.
  int          slv_mode = 0, slv_dly = 0, slv_cnt = 0;
  bit          slv_err = 1'b0, slv_err_idle = 1'b0, slv_active = 1'b0, late_ack = 1'b0;
  logic [31:0] slv_rdata = '0;

  always @(negedge clk_i) begin
    sys_ack_i   = 1'b0;
    sys_err_i   = slv_err_idle;
    sys_rdata_i = 32'hBAD0_BAD0;
    if (rstn_i) begin
      if ((sys_wen_o || sys_ren_o) && slv_mode == 0) begin
        slv_active = 1'b1;
        slv_cnt    = slv_dly;
      end
      if (slv_active) begin
        if (slv_cnt == 0) begin
          sys_ack_i   = 1'b1;
          sys_err_i   = slv_err;
          sys_rdata_i = slv_rdata;
          slv_active  = 1'b0;
        end else begin
          slv_cnt--;
        end
      end
      if (late_ack) begin
        sys_ack_i = 1'b1;
        late_ack  = 1'b0;
      end
    end
  end

  iss_t ie;
  cpl_t ce;
  always @(negedge clk_i) begin
    if (rstn_i) begin
      if (sys_wen_o || sys_ren_o) begin
        iss_cyc = cyc;
        if (iss_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_issue: got addr 0x%0h, expected no issue", sys_addr_o);
        end else begin
          ie = iss_q.pop_front();
          chk("iss_addr", sys_addr_o, ie.addr);
          chk("iss_wdata", sys_wdata_o, ie.wdata);
          chk("iss_wen", sys_wen_o, ie.w);
          chk("iss_ren", sys_ren_o, !ie.w);
        end
      end
      for (int k = 0; k < N; k++) begin
        if (m_ack_o[k]) begin
          ack_cyc = cyc;
          ack_count++;
          if (cpl_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_ack: got ack on master %0d, expected none", k);
          end else begin
            ce = cpl_q.pop_front();
            chk("cpl_master", k, ce.m);
            chk("cpl_err", m_err_o[k], ce.err);
            chk("cpl_rdata", m_rdata_o[k*DW +: DW], ce.rdata);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
    m_wen_i = '0;
    m_ren_i = '0;
  endtask

  task automatic drive(int k, bit w, bit r, logic [AW-1:0] a, logic [DW-1:0] d);
    m_addr_i[k*AW +: AW]  = a;
    m_wdata_i[k*DW +: DW] = d;
    m_wen_i[k] = w;
    m_ren_i[k] = r;
  endtask

  task automatic exp_txn(int k, bit w, logic [AW-1:0] a, logic [DW-1:0] d, bit err, logic [DW-1:0] rd);
    iss_t i;
    cpl_t c;
    i.addr = a; i.wdata = d; i.w = w;
    c.m = k; c.err = err; c.rdata = rd;
    iss_q.push_back(i);
    cpl_q.push_back(c);
  endtask

  task automatic wait_idle(int budget);
    int b;
    b = budget;
    while ((iss_q.size() != 0 || cpl_q.size() != 0) && b > 0) begin
      tick();
      b--;
    end
    if (iss_q.size() != 0 || cpl_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: got %0d issues / %0d acks outstanding, expected 0", iss_q.size(), cpl_q.size());
      iss_q.delete();
      cpl_q.delete();
    end
    repeat (4) tick();
  endtask

  typedef struct {
    int m; bit w; bit r; logic [31:0] addr; logic [31:0] wdata;
    int dly; bit err; bit noise; logic [31:0] rdata;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int req_cyc, cnt0, b;
    vecs[0] = '{0, 1'b0, 1'b1, 32'h4000_0010, 32'h0,         2, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1, 1'b1, 1'b0, 32'h0000_1000, 32'hA5A5_A5A5, 1, 1'b0, 1'b0, 32'hCAFE_F00D};
    vecs[2] = '{0, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0033, 0, 1'b1, 1'b0, 32'h1234_5678};
    vecs[3] = '{1, 1'b0, 1'b1, 32'h0000_0030, 32'h0,         0, 1'b1, 1'b0, 32'h0000_1234};
    vecs[4] = '{0, 1'b0, 1'b1, 32'h0000_0044, 32'h0,         5, 1'b0, 1'b1, 32'h55AA_55AA};
    vecs[5] = '{1, 1'b1, 1'b1, 32'h0000_0050, 32'h0000_0077, 1, 1'b0, 1'b0, 32'h0};

    repeat (3) @(negedge clk_i);
    chk("rst_sys_wen", sys_wen_o, 0);
    chk("rst_sys_ren", sys_ren_o, 0);
    chk("rst_sys_addr", sys_addr_o, 0);
    chk("rst_m_ack", m_ack_o, 0);
    chk("rst_m_rdata", m_rdata_o, 0);
    chk("rst_ovr", ovr_o, 0);
    rstn_i = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) begin
      slv_dly      = vecs[i].dly;
      slv_err      = vecs[i].err;
      slv_err_idle = vecs[i].noise;
      slv_rdata    = vecs[i].rdata;
      req_cyc      = cyc;
      drive(vecs[i].m, vecs[i].w, vecs[i].r, vecs[i].addr, vecs[i].wdata);
      exp_txn(vecs[i].m, vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].err,
              vecs[i].w ? 32'h0 : vecs[i].rdata);
      tick();
      wait_idle(100);
      chk($sformatf("v%0d_req_to_issue", i), iss_cyc - req_cyc, 2);
      chk($sformatf("v%0d_issue_to_ack", i), ack_cyc - iss_cyc, vecs[i].dly + 1);
    end
    slv_err_idle = 1'b0;
    slv_err      = 1'b0;

    // Rotation: last grant was master 1, so master 0 wins the first pair.
    slv_dly = 1;
    drive(0, 1'b1, 1'b0, 32'h100, 32'h11);
    drive(1, 1'b1, 1'b0, 32'h200, 32'h22);
    exp_txn(0, 1'b1, 32'h100, 32'h11, 1'b0, 32'h0);
    exp_txn(1, 1'b1, 32'h200, 32'h22, 1'b0, 32'h0);
    tick();
    wait_idle(100);
    drive(0, 1'b1, 1'b0, 32'h104, 32'h44);
    exp_txn(0, 1'b1, 32'h104, 32'h44, 1'b0, 32'h0);
    tick();
    wait_idle(100);
    drive(0, 1'b1, 1'b0, 32'h100, 32'h11);
    drive(1, 1'b1, 1'b0, 32'h200, 32'h22);
    exp_txn(1, 1'b1, 32'h200, 32'h22, 1'b0, 32'h0);
    exp_txn(0, 1'b1, 32'h100, 32'h11, 1'b0, 32'h0);
    tick();
    wait_idle(100);

    // Overrun: second request from master 1 while its slot is still pending.
    slv_dly = 6;
    drive(1, 1'b1, 1'b0, 32'h300, 32'h99);
    exp_txn(1, 1'b1, 32'h300, 32'h99, 1'b0, 32'h0);
    tick();
    tick();
    drive(1, 1'b0, 1'b1, 32'h304, 32'h0);
    tick();
    wait_idle(100);
    chk("ovr_set", ovr_o, 2'b10);

    // Timeout with a dead slave, then a stray late ack.
    slv_mode = 1;
    drive(0, 1'b0, 1'b1, 32'h400, 32'h0);
    exp_txn(0, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0);
    tick();
    wait_idle(200);
    chk("tmo_latency", ack_cyc - iss_cyc, 32);
    cnt0 = ack_count;
    late_ack = 1'b1;
    repeat (8) tick();
    chk("late_ack_ignored", ack_count, cnt0);
    chk("ovr_sticky", ovr_o, 2'b10);

    // Reset while master 0 is in WAIT with master 1 queued.
    drive(0, 1'b0, 1'b1, 32'h500, 32'h0);
    begin
      iss_t i5;
      i5.addr = 32'h500; i5.wdata = 32'h0; i5.w = 1'b0;
      iss_q.push_back(i5);
    end
    tick();
    drive(1, 1'b1, 1'b0, 32'h600, 32'h66);
    tick();
    b = 10;
    while (iss_q.size() != 0 && b > 0) begin
      tick();
      b--;
    end
    chk("pre_reset_issued", iss_q.size(), 0);
    repeat (3) tick();
    rstn_i = 1'b0;
    #1;
    chk("arst_sys_wen", sys_wen_o, 0);
    chk("arst_sys_ren", sys_ren_o, 0);
    chk("arst_sys_addr", sys_addr_o, 0);
    chk("arst_sys_wdata", sys_wdata_o, 0);
    chk("arst_m_ack", m_ack_o, 0);
    chk("arst_m_err", m_err_o, 0);
    chk("arst_m_rdata", m_rdata_o, 0);
    chk("arst_ovr", ovr_o, 0);
    iss_q.delete();
    cpl_q.delete();
    slv_active = 1'b0;
    slv_mode   = 0;
    late_ack   = 1'b0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (6) tick();
    slv_dly = 1;
    drive(0, 1'b1, 1'b0, 32'h700, 32'h70);
    drive(1, 1'b1, 1'b0, 32'h800, 32'h80);
    exp_txn(0, 1'b1, 32'h700, 32'h70, 1'b0, 32'h0);
    exp_txn(1, 1'b1, 32'h800, 32'h80, 1'b0, 32'h0);
    tick();
    wait_idle(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion of the test sequence, expected it within 20000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
